// File: rtl/control_race_multi_if.sv
// Datapath-facing bundle of the race controller: draw commands, move strobe
// and car addressing going out, drawer handshake and finish flags coming back.
interface control_race_multi_if #(
  parameter int NUM_CARS = 4
);
  localparam int SEL_W = $clog2(NUM_CARS);

  logic [NUM_CARS-1:0] win;
  logic                draw_done;
  logic                reset_signals;
  logic                draw_start_screen;
  logic                draw_background;
  logic                draw_car;
  logic                erase_car;
  logic                draw_win_screen;
  logic                plot;
  logic [SEL_W-1:0]    car_sel;
  logic                move_car;
  logic [1:0]          move_dir;

  modport master (
    input  win, draw_done,
    output reset_signals, draw_start_screen, draw_background, draw_car,
           erase_car, draw_win_screen, plot, car_sel, move_car, move_dir
  );

  modport slave (
    output win, draw_done,
    input  reset_signals, draw_start_screen, draw_background, draw_car,
           erase_car, draw_win_screen, plot, car_sel, move_car, move_dir
  );
endinterface

// File: rtl/control_race_multi.sv
// Game-flow controller for the multi-car race: start screen, countdown,
// per-frame erase/move/redraw of pending cars, win screen, draw watchdog.
// Command outputs are registered from the next state so they reflect the
// current state exactly and are all low while reset is held.
module control_race_multi #(
  parameter int NUM_CARS         = 4,
  parameter int COUNT_FROM       = 3,
  parameter int FRAMES_PER_COUNT = 60,
  parameter int DRAW_TIMEOUT     = 19200
) (
  input  logic                        Clock,
  input  logic                        resetn,
  input  logic                        start,
  input  logic                        frame_tick,
  input  logic [NUM_CARS-1:0]         fwd,
  input  logic [NUM_CARS-1:0]         left,
  input  logic [NUM_CARS-1:0]         right,
  control_race_multi_if.master        dp,
  output logic [2:0]                  countdown,
  output logic [$clog2(NUM_CARS)-1:0] winner_id,
  output logic                        timeout_err
);
  localparam int SEL_W = $clog2(NUM_CARS);
  localparam int WD_W  = $clog2(DRAW_TIMEOUT + 1);
  localparam int FC_W  = $clog2(FRAMES_PER_COUNT + 1);

  typedef enum logic [3:0] {
    S_START_SCREEN, S_WAIT_START, S_RESET_SIG, S_DRAW_BG, S_DRAW_ALL,
    S_COUNTDOWN, S_WAIT_FRAME, S_ERASE, S_MOVE, S_REDRAW, S_WIN_SCREEN
  } state_t;

  state_t              state, state_nxt;
  logic [SEL_W-1:0]    car_sel_q, car_sel_nxt;
  logic [SEL_W-1:0]    winner_q, winner_nxt;
  logic [NUM_CARS-1:0] pending_q, pending_nxt;
  logic [1:0]          dir_q   [NUM_CARS];
  logic [1:0]          dir_nxt [NUM_CARS];
  logic [2:0]          countdown_q;
  logic [FC_W-1:0]     fcnt_q;
  logic [WD_W-1:0]     wd_q;
  logic                is_draw, wd_hit, done_eff, lat_en;

  function automatic logic draw_state(input state_t s);
    return (s == S_START_SCREEN) || (s == S_DRAW_BG) || (s == S_DRAW_ALL) ||
           (s == S_ERASE) || (s == S_REDRAW) || (s == S_WIN_SCREEN);
  endfunction

  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_CARS-1:0] v);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = NUM_CARS - 1; i >= 0; i--)
      if (v[i]) r = SEL_W'(i);
    return r;
  endfunction

  assign is_draw  = draw_state(state);
  assign wd_hit   = is_draw && (wd_q == WD_W'(DRAW_TIMEOUT - 1));
  assign done_eff = is_draw && (dp.draw_done || wd_hit);
  assign lat_en   = (state == S_WAIT_FRAME) || (state == S_ERASE) ||
                    (state == S_MOVE) || (state == S_REDRAW);

  assign dp.car_sel = car_sel_q;
  assign countdown  = countdown_q;
  assign winner_id  = winner_q;

  // State, car index and winner registers
  always_ff @(posedge Clock or negedge resetn) begin
    if (!resetn) begin
      state     <= S_START_SCREEN;
      car_sel_q <= '0;
      winner_q  <= '0;
    end else begin
      state     <= state_nxt;
      car_sel_q <= car_sel_nxt;
      winner_q  <= winner_nxt;
    end
  end

  // Next-state logic; a watchdog expiry counts as draw_done
  always_comb begin
    state_nxt   = state;
    car_sel_nxt = car_sel_q;
    winner_nxt  = winner_q;
    case (state)
      S_START_SCREEN: if (done_eff) state_nxt = S_WAIT_START;
      S_WAIT_START:   if (start) state_nxt = S_RESET_SIG;
      S_RESET_SIG:    state_nxt = S_DRAW_BG;
      S_DRAW_BG: if (done_eff) begin
        state_nxt   = S_DRAW_ALL;
        car_sel_nxt = '0;
      end
      S_DRAW_ALL: if (done_eff) begin
        if (car_sel_q != SEL_W'(NUM_CARS - 1)) car_sel_nxt = car_sel_q + SEL_W'(1);
        else if (countdown_q != 3'd0)           state_nxt   = S_COUNTDOWN;
        else                                    state_nxt   = S_WAIT_FRAME;
      end
      S_COUNTDOWN: if (countdown_q == 3'd0) state_nxt = S_WAIT_FRAME;
      S_WAIT_FRAME: begin
        if (start) state_nxt = S_RESET_SIG;
        else if (frame_tick) begin
          if (|dp.win) begin
            state_nxt  = S_WIN_SCREEN;
            winner_nxt = lowest_set(dp.win);
          end else if (|pending_q) begin
            state_nxt   = S_ERASE;
            car_sel_nxt = lowest_set(pending_q);
          end
        end
      end
      S_ERASE: if (done_eff) state_nxt = S_MOVE;
      S_MOVE:  state_nxt = S_REDRAW;
      S_REDRAW: if (done_eff) begin
        if (|pending_q) begin
          state_nxt   = S_ERASE;
          car_sel_nxt = lowest_set(pending_q);
        end else begin
          state_nxt = S_WAIT_FRAME;
        end
      end
      S_WIN_SCREEN: if (done_eff) state_nxt = S_WAIT_START;
      default:      state_nxt = S_START_SCREEN;
    endcase
  end

  // Move-request latching: first request per car wins, a new request for the
  // car being moved re-arms it after its pending bit is cleared
  always_comb begin
    pending_nxt = pending_q;
    dir_nxt     = dir_q;
    if (state == S_RESET_SIG) begin
      pending_nxt = '0;
      for (int i = 0; i < NUM_CARS; i++) dir_nxt[i] = 2'b00;
    end else if (lat_en) begin
      if (state == S_MOVE) pending_nxt[car_sel_q] = 1'b0;
      for (int i = 0; i < NUM_CARS; i++) begin
        if ((fwd[i] || left[i] || right[i]) && !pending_nxt[i]) begin
          pending_nxt[i] = 1'b1;
          dir_nxt[i]     = fwd[i] ? 2'b00 : (left[i] ? 2'b01 : 2'b10);
        end
      end
    end
  end

  // Pending mask and per-car direction registers
  always_ff @(posedge Clock or negedge resetn) begin
    if (!resetn) begin
      pending_q <= '0;
      for (int i = 0; i < NUM_CARS; i++) dir_q[i] <= 2'b00;
    end else begin
      pending_q <= pending_nxt;
      dir_q     <= dir_nxt;
    end
  end

  // Countdown: load on signal reset, step down every FRAMES_PER_COUNT ticks
  always_ff @(posedge Clock or negedge resetn) begin
    if (!resetn) begin
      countdown_q <= 3'd0;
      fcnt_q      <= '0;
    end else if (state == S_RESET_SIG) begin
      countdown_q <= 3'(COUNT_FROM);
      fcnt_q      <= '0;
    end else if (state == S_COUNTDOWN && countdown_q != 3'd0 && frame_tick) begin
      if (fcnt_q == FC_W'(FRAMES_PER_COUNT - 1)) begin
        fcnt_q      <= '0;
        countdown_q <= countdown_q - 3'd1;
      end else begin
        fcnt_q <= fcnt_q + FC_W'(1);
      end
    end
  end

  // Draw watchdog: restarts for every drawn object, sticky error on expiry
  always_ff @(posedge Clock or negedge resetn) begin
    if (!resetn) begin
      wd_q        <= '0;
      timeout_err <= 1'b0;
    end else begin
      wd_q <= (is_draw && !done_eff) ? wd_q + WD_W'(1) : '0;
      if (state == S_RESET_SIG)           timeout_err <= 1'b0;
      else if (wd_hit && !dp.draw_done)   timeout_err <= 1'b1;
    end
  end

  // Moore command outputs, registered from the next state
  always_ff @(posedge Clock or negedge resetn) begin
    if (!resetn) begin
      dp.reset_signals     <= 1'b0;
      dp.draw_start_screen <= 1'b0;
      dp.draw_background   <= 1'b0;
      dp.draw_car          <= 1'b0;
      dp.erase_car         <= 1'b0;
      dp.draw_win_screen   <= 1'b0;
      dp.plot              <= 1'b0;
      dp.move_car          <= 1'b0;
      dp.move_dir          <= 2'b00;
    end else begin
      dp.reset_signals     <= (state_nxt == S_RESET_SIG);
      dp.draw_start_screen <= (state_nxt == S_START_SCREEN);
      dp.draw_background   <= (state_nxt == S_DRAW_BG);
      dp.draw_car          <= (state_nxt == S_DRAW_ALL) || (state_nxt == S_REDRAW);
      dp.erase_car         <= (state_nxt == S_ERASE);
      dp.draw_win_screen   <= (state_nxt == S_WIN_SCREEN);
      dp.plot              <= draw_state(state_nxt);
      dp.move_car          <= (state_nxt == S_MOVE);
      dp.move_dir          <= (state_nxt == S_MOVE) ? dir_nxt[car_sel_nxt] : 2'b00;
    end
  end
endmodule

// File: tb/tb_control_race_multi.sv
// Directed bench for the race controller: start screen, countdown, move
// servicing order and direction latching, win screen, draw watchdog, reset.
module tb_control_race_multi;
  localparam int NUM_CARS = 4;

  // {reset_signals, start_screen, background, car, erase, win_screen, plot, move_car}
  localparam logic [7:0] C_IDLE = 8'b0000_0000;
  localparam logic [7:0] C_RST  = 8'b1000_0000;
  localparam logic [7:0] C_SS   = 8'b0100_0010;
  localparam logic [7:0] C_BG   = 8'b0010_0010;
  localparam logic [7:0] C_CAR  = 8'b0001_0010;
  localparam logic [7:0] C_ERA  = 8'b0000_1010;
  localparam logic [7:0] C_WIN  = 8'b0000_0110;
  localparam logic [7:0] C_MOV  = 8'b0000_0001;

  logic                Clock = 1'b0;
  logic                resetn;
  logic                start, frame_tick;
  logic [NUM_CARS-1:0] fwd, left, right;
  logic [2:0]          countdown;
  logic [1:0]          winner_id;
  logic                timeout_err;
  logic [7:0]          cmd;
  int                  n_cmp = 0;
  int                  n_err = 0;
  int                  n;

  control_race_multi_if #(.NUM_CARS(NUM_CARS)) dp ();

  control_race_multi #(
    .NUM_CARS(NUM_CARS), .COUNT_FROM(3), .FRAMES_PER_COUNT(2), .DRAW_TIMEOUT(16)
  ) dut (
    .Clock(Clock), .resetn(resetn), .start(start), .frame_tick(frame_tick),
    .fwd(fwd), .left(left), .right(right), .dp(dp),
    .countdown(countdown), .winner_id(winner_id), .timeout_err(timeout_err)
  );

  always #5 Clock = ~Clock;

  assign cmd = {dp.reset_signals, dp.draw_start_screen, dp.draw_background, dp.draw_car,
                dp.erase_car, dp.draw_win_screen, dp.plot, dp.move_car};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic do_draw(input string tag, input logic [7:0] exp_cmd);
    check(tag, cmd, exp_cmd);
    dp.draw_done = 1'b1;
    step();
    dp.draw_done = 1'b0;
  endtask

  task automatic chk_move(input string tag, input int sel, input logic [1:0] dir);
    check({tag, "_cmd"}, cmd, C_MOV);
    check({tag, "_sel"}, dp.car_sel, sel);
    check({tag, "_dir"}, dp.move_dir, dir);
    step();
  endtask

  task automatic draw_cars();
    for (int c = 0; c < NUM_CARS; c++) begin
      check("all_sel", dp.car_sel, c);
      do_draw("all_cmd", C_CAR);
    end
  endtask

  // Countdown from 3 with two frame ticks per step; forward requests here are ignored
  task automatic run_countdown();
    fwd = '1;
    step();
    fwd = '0;
    for (int v = 3; v > 0; v--) begin
      check("cd_val", countdown, v);
      tick();
      step();
      tick();
    end
    check("cd_zero", countdown, 0);
    step();
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; frame_tick = 1'b0;
    fwd = '0; left = '0; right = '0;
    dp.win = '0; dp.draw_done = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    check("rst_cmd", cmd, C_IDLE);
    check("rst_sel", dp.car_sel, 0);
    check("rst_cd", countdown, 0);
    check("rst_tmo", timeout_err, 0);
    check("rst_dir", dp.move_dir, 0);
    resetn = 1'b1;

    // Start screen held five cycles, done on the fifth
    for (int i = 0; i < 5; i++) begin
      step();
      check("ss_cmd", cmd, C_SS);
      if (i == 4) dp.draw_done = 1'b1;
    end
    step();
    dp.draw_done = 1'b0;
    check("ws_cmd", cmd, C_IDLE);
    step();
    check("ws_hold", cmd, C_IDLE);
    start = 1'b1;
    step();
    start = 1'b0;
    check("rsig_cmd", cmd, C_RST);
    step();
    check("rsig_once", cmd, C_BG);
    check("cd_load", countdown, 3);

    // Background, four cars, countdown
    do_draw("bg_cmd", C_BG);
    draw_cars();
    run_countdown();
    tick();
    check("no_latch", cmd, C_IDLE);

    // Two cars requested in the same cycle, serviced lowest index first
    left = 4'b0100; fwd = 4'b0001;
    step();
    left = '0; fwd = '0;
    tick();
    check("er0_sel", dp.car_sel, 0);
    do_draw("er0_cmd", C_ERA);
    chk_move("mv0", 0, 2'b00);
    do_draw("rd0_cmd", C_CAR);
    check("er2_sel", dp.car_sel, 2);
    do_draw("er2_cmd", C_ERA);
    chk_move("mv2", 2, 2'b01);
    do_draw("rd2_cmd", C_CAR);
    check("wf3_cmd", cmd, C_IDLE);

    // First request wins; request during MOVE re-arms the car
    left = 4'b0010;
    step();
    left = '0; right = 4'b0010;
    step();
    right = '0;
    tick();
    check("er1_sel", dp.car_sel, 1);
    do_draw("er1_cmd", C_ERA);
    check("mv1_cmd", cmd, C_MOV);
    check("mv1_sel", dp.car_sel, 1);
    check("mv1_dir", dp.move_dir, 2'b01);
    fwd = 4'b0010;
    step();
    fwd = '0;
    do_draw("rd1_cmd", C_CAR);
    check("er1b_sel", dp.car_sel, 1);
    do_draw("er1b_cmd", C_ERA);
    chk_move("mv1b", 1, 2'b00);
    do_draw("rd1b_cmd", C_CAR);
    check("wf4_cmd", cmd, C_IDLE);

    // Two winners, lowest index reported
    dp.win = 4'b1010;
    tick();
    dp.win = '0;
    check("win_id", winner_id, 1);
    do_draw("win_cmd", C_WIN);
    check("ws2_cmd", cmd, C_IDLE);
    check("ws2_id", winner_id, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("rsig2_cmd", cmd, C_RST);
    step();
    check("bg2_cmd", cmd, C_BG);
    check("bg2_tmo", timeout_err, 0);

    // Withheld draw_done: watchdog releases the background draw after 16 cycles
    n = 0;
    while (cmd == C_BG && n < 40) begin
      n++;
      step();
    end
    check("wd_cycles", n, 16);
    check("wd_err", timeout_err, 1);
    check("wd_next", cmd, C_CAR);
    draw_cars();
    check("wd_sticky", timeout_err, 1);
    run_countdown();
    start = 1'b1;
    step();
    start = 1'b0;
    check("rsig3_cmd", cmd, C_RST);
    step();
    check("tmo_clr", timeout_err, 0);
    check("bg3_cmd", cmd, C_BG);

    // draw_done on the same cycle the watchdog expires is a normal done
    repeat (15) step();
    check("bg3_hold", cmd, C_BG);
    dp.draw_done = 1'b1;
    step();
    dp.draw_done = 1'b0;
    check("both_next", cmd, C_CAR);
    check("both_tmo", timeout_err, 0);

    // Asynchronous reset in the middle of a car draw
    #2;
    resetn = 1'b0;
    #1;
    check("areset_cmd", cmd, C_IDLE);
    check("areset_sel", dp.car_sel, 0);
    check("areset_cd", countdown, 0);
    @(posedge Clock);
    #1;
    resetn = 1'b1;
    step();
    check("areset_ss", cmd, C_SS);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
